// File: rtl/imm_operand_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : imm_operand_sequencer
// Description : Sequences the 8->16 sign_extend unit for short immediates and
//               assembles long immediates from a second instruction byte.
//               Optional issue counter enabled by defining OPSEQ_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module imm_operand_sequencer #(
    parameter int TIMEOUT_CYC = 255,
    parameter int CNT_W       = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid_i,
    output logic        instr_ready_o,
    input  logic [7:0]  instr_imm_i,
    input  logic        instr_signed_i,
    input  logic        instr_acc_op_i,
    input  logic        instr_long_i,
    input  logic        byte_valid_i,
    output logic        byte_ready_o,
    input  logic [7:0]  byte_i,
    output logic [7:0]  ext_val_o,
    output logic        ext_acc_s_o,
    output logic        ext_acc_op_o,
    input  logic [15:0] ext_out_i,
    output logic        opnd_valid_o,
    input  logic        opnd_ready_i,
    output logic [15:0] opnd_o,
    output logic        opnd_long_o,
`ifdef OPSEQ_STATS_EN
    output logic [CNT_W-1:0] issue_cnt_o,
`endif
    output logic        busy_o,
    output logic        err_o
);

    localparam int c_TO_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
    localparam logic [c_TO_W-1:0] c_TO_LAST = c_TO_W'(TIMEOUT_CYC - 1);

    // S_LOAD registers the latched request onto the sign_extend inputs so
    // they are stable for the whole S_EXT cycle.
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_EXT     = 3'd2,
        S_WAIT_HI = 3'd3,
        S_ISSUE   = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [7:0]        r_imm;
    logic              r_signed;
    logic              r_acc_op;
    logic [c_TO_W-1:0] r_to_cnt;
    logic [7:0]        r_ext_val;
    logic              r_ext_acc_s;
    logic              r_ext_acc_op;
    logic [15:0]       r_opnd;
    logic              r_opnd_long;
    logic              r_err;
    logic              w_accept;
    logic              w_byte_take;
    logic              w_expire;
    logic              w_issue_hs;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_accept    = 1'b0;
        w_byte_take = 1'b0;
        w_expire    = 1'b0;
        w_issue_hs  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (instr_valid_i) begin
                    w_accept = 1'b1;
                    w_next   = instr_long_i ? S_WAIT_HI : S_LOAD;
                end
            end
            S_LOAD:  w_next = S_EXT;
            S_EXT:   w_next = S_ISSUE;
            S_WAIT_HI: begin
                // A byte arriving in the expiry cycle takes priority.
                if (byte_valid_i) begin
                    w_byte_take = 1'b1;
                    w_next      = S_ISSUE;
                end else if (r_to_cnt == c_TO_LAST) begin
                    w_expire = 1'b1;
                    w_next   = S_IDLE;
                end
            end
            S_ISSUE: begin
                if (opnd_ready_i) begin
                    w_issue_hs = 1'b1;
                    w_next     = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_imm        <= 8'h00;
            r_signed     <= 1'b0;
            r_acc_op     <= 1'b0;
            r_to_cnt     <= '0;
            r_ext_val    <= 8'h00;
            r_ext_acc_s  <= 1'b0;
            r_ext_acc_op <= 1'b0;
            r_opnd       <= 16'h0000;
            r_opnd_long  <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_err <= w_expire;
            if (w_accept) begin
                r_imm    <= instr_imm_i;
                r_signed <= instr_signed_i;
                r_acc_op <= instr_acc_op_i;
                r_to_cnt <= '0;
            end
            if (r_state == S_LOAD) begin
                r_ext_val    <= r_imm;
                r_ext_acc_s  <= r_signed;
                r_ext_acc_op <= r_acc_op;
            end
            if (r_state == S_EXT) begin
                r_opnd      <= ext_out_i;
                r_opnd_long <= 1'b0;
            end
            if ((r_state == S_WAIT_HI) && !byte_valid_i) begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end
            if (w_byte_take) begin
                r_opnd      <= {byte_i, r_imm};
                r_opnd_long <= 1'b1;
            end
        end
    end

`ifdef OPSEQ_STATS_EN
    logic [CNT_W-1:0] r_issue_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_issue_cnt <= '0;
        end else if (w_issue_hs) begin
            r_issue_cnt <= r_issue_cnt + 1'b1;
        end
    end

    assign issue_cnt_o = r_issue_cnt;
`endif

    assign instr_ready_o = (r_state == S_IDLE) && !rst;
    assign byte_ready_o  = (r_state == S_WAIT_HI) && !rst;
    assign opnd_valid_o  = (r_state == S_ISSUE) && !rst;
    assign busy_o        = (r_state != S_IDLE);
    assign err_o         = r_err;
    assign ext_val_o     = r_ext_val;
    assign ext_acc_s_o   = r_ext_acc_s;
    assign ext_acc_op_o  = r_ext_acc_op;
    assign opnd_o        = r_opnd;
    assign opnd_long_o   = r_opnd_long;

endmodule
`default_nettype wire
